// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/valid fetch bus
interface instr_fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 12
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC and IR with request/valid fetch FSM
// Optional wait-state timeout is built when IFETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
  parameter int              DATA_W         = 16,
  parameter int              PC_W           = 12,
  parameter logic [PC_W-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_ir,
  input  logic               load_pc,
  input  logic               inc_pc,
  input  logic               sel_a,
  instr_fetch_unit_if.master imem,
  output logic [DATA_W-1:0]  ir,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    addr_field,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_busy,
  output logic               ir_valid,
  output logic               fetch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              timeout_hit;

  // Jump reads ir_q, so a same-edge IR capture never feeds the new PC.
  always_comb begin
    pc_d = pc_q;
    if (load_pc && sel_a) begin
      pc_d = ir_q[PC_W-1:0];
    end else if (inc_pc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_ir) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem.imem_valid) begin
          ir_d       = imem.imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_valid) begin
          ir_d       = imem.imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (timeout_hit) begin
          ir_d       = '0;
          ir_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counts WAIT cycles without data; any other state clears it, so REQ always starts fresh.
  assign timeout_hit = (state_q == S_WAIT) && !imem.imem_valid &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign fetch_err             = 1'b0;
`endif

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = addr_q;
  assign fetch_busy     = (state_q != S_IDLE);
  assign ir             = ir_q;
  assign opcode         = ir_q[DATA_W-1 -: 4];
  assign addr_field     = ir_q[PC_W-1:0];
  assign pc             = pc_q;
  assign ir_valid       = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int DATA_W         = 16;
  localparam int PC_W           = 12;
  localparam int TIMEOUT_CYCLES = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_ir, load_pc, inc_pc, sel_a;
  logic [DATA_W-1:0] ir;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   addr_field, pc;
  logic              fetch_busy, ir_valid, fetch_err;

  instr_fetch_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W)) imem_bus ();

  instr_fetch_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(12'h000), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_ir(load_ir), .load_pc(load_pc), .inc_pc(inc_pc),
    .sel_a(sel_a), .imem(imem_bus), .ir(ir), .opcode(opcode), .addr_field(addr_field),
    .pc(pc), .fetch_busy(fetch_busy), .ir_valid(ir_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a fetch is "in flight" with an age (0 = request cycle).
  logic [PC_W-1:0]   m_pc, m_addr;
  logic [DATA_W-1:0] m_ir;
  bit                m_busy, m_irv, m_err;
  int                m_age;
  int                req_count;
  logic [DATA_W-1:0] mem [0:(1<<PC_W)-1];
  int                resp_cnt;
  logic [PC_W-1:0]   resp_addr;

  task automatic model_reset();
    m_pc = '0; m_addr = '0; m_ir = '0;
    m_busy = 0; m_irv = 0; m_err = 0; m_age = 0;
  endtask

  task automatic model_step(input bit li, lp, ip, sa, v, input logic [DATA_W-1:0] rd);
    logic [PC_W-1:0] nxt_pc;
    nxt_pc = m_pc;
    if (lp && sa) nxt_pc = m_ir[PC_W-1:0];
    else if (ip)  nxt_pc = PC_W'((int'(m_pc) + 1) % (1 << PC_W));
    m_irv = 0;
    if (!m_busy) begin
      if (li) begin m_busy = 1; m_age = 0; m_addr = m_pc; end
    end else if (v) begin
      m_ir = rd; m_irv = 1; m_busy = 0;
    end else begin
`ifdef IFETCH_TIMEOUT_EN
      if (m_age == TIMEOUT_CYCLES) begin
        m_ir = '0; m_irv = 1; m_err = 1; m_busy = 0;
      end
`endif
      m_age++;
    end
    m_pc = nxt_pc;
  endtask

  task automatic check_outputs();
    check_eq("imem_req",   imem_bus.imem_req, m_busy && (m_age == 0));
    check_eq("imem_addr",  imem_bus.imem_addr, m_addr);
    check_eq("ir",         ir, m_ir);
    check_eq("opcode",     opcode, m_ir[15:12]);
    check_eq("addr_field", addr_field, m_ir[11:0]);
    check_eq("pc",         pc, m_pc);
    check_eq("fetch_busy", fetch_busy, m_busy);
    check_eq("ir_valid",   ir_valid, m_irv);
    check_eq("fetch_err",  fetch_err, m_err);
    if (imem_bus.imem_req === 1'b1) req_count++;
  endtask

  task automatic cycle(input bit li, lp, ip, sa, v, input logic [DATA_W-1:0] rd);
    load_ir = li; load_pc = lp; inc_pc = ip; sel_a = sa;
    imem_bus.imem_valid = v; imem_bus.imem_rdata = rd;
    model_step(li, lp, ip, sa, v, rd);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit                v;
    logic [DATA_W-1:0] rd;

    rst_n = 1'b0; load_ir = 0; load_pc = 0; inc_pc = 0; sel_a = 0;
    imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = '0;
    req_count = 0; resp_cnt = -1; resp_addr = '0;
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = DATA_W'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("rst_pc", pc, 12'h000);
    check_eq("rst_ir", ir, 16'h0000);
    rst_n = 1'b1;

    // zero-wait fetch at pc=0x005
    repeat (5) cycle(0, 0, 1, 0, 0, '0);
    check_eq("pc_five", pc, 12'h005);
    cycle(1, 0, 0, 0, 0, '0);
    check_eq("zw_req", imem_bus.imem_req, 1);
    check_eq("zw_addr", imem_bus.imem_addr, 12'h005);
    cycle(0, 0, 0, 0, 1, 16'h4123);
    check_eq("zw_ir", ir, 16'h4123);
    check_eq("zw_opcode", opcode, 4'h4);
    check_eq("zw_field", addr_field, 12'h123);
    check_eq("zw_irv", ir_valid, 1);
    check_eq("zw_busy", fetch_busy, 0);
    idle(1);
    check_eq("zw_irv_off", ir_valid, 0);

    // wait-state fetch, inc_pc in flight, ignored second load_ir
    req_count = 0;
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 0, '0);
    check_eq("ws_pc", pc, 12'h006);
    check_eq("ws_addr", imem_bus.imem_addr, 12'h005);
    cycle(1, 0, 0, 0, 0, '0);
    idle(1);
    check_eq("ws_busy", fetch_busy, 1);
    cycle(0, 0, 0, 0, 1, 16'h7ABC);
    check_eq("ws_ir", ir, 16'h7ABC);
    check_eq("ws_reqs", req_count, 1);
    idle(1);
    check_eq("ws_idle_req", imem_bus.imem_req, 0);

    // jump priority, hold, wrap
    cycle(0, 1, 1, 1, 0, '0);
    check_eq("jmp_pc", pc, 12'hABC);
    cycle(0, 1, 0, 0, 0, '0);
    check_eq("hold_pc", pc, 12'hABC);
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 1, 16'h0FFF);
    cycle(0, 1, 0, 1, 0, '0);
    check_eq("jmp_fff", pc, 12'hFFF);
    cycle(0, 0, 1, 0, 0, '0);
    check_eq("wrap_pc", pc, 12'h000);

    // randomized traffic with a latency-varying memory responder
    for (int c = 0; c < 3000; c++) begin
      if (imem_bus.imem_req === 1'b1) begin
        resp_addr = imem_bus.imem_addr;
        resp_cnt  = ($urandom_range(0, 15) == 0) ? 18 : int'($urandom_range(0, 3));
      end
      v  = 0;
      rd = DATA_W'($urandom);
      if (resp_cnt == 0) begin
        v = 1; rd = mem[resp_addr]; resp_cnt = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        v = 1;
      end
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, v, rd);
    end
    if (m_busy) cycle(0, 0, 0, 0, 1, 16'h0000);
    idle(1);
    check_eq("drain_busy", fetch_busy, 0);

    // no response for a full timeout window
    cycle(1, 0, 0, 0, 0, '0);
    idle(TIMEOUT_CYCLES);
    check_eq("to_edge_busy", fetch_busy, 1);
    idle(1);
`ifdef IFETCH_TIMEOUT_EN
    check_eq("to_ir", ir, 16'h0000);
    check_eq("to_irv", ir_valid, 1);
    check_eq("to_err", fetch_err, 1);
    idle(3);
    check_eq("to_err_sticky", fetch_err, 1);
`else
    check_eq("nto_busy", fetch_busy, 1);
    check_eq("nto_err", fetch_err, 0);
    idle(4);
    check_eq("nto_busy_late", fetch_busy, 1);
    cycle(0, 0, 0, 0, 1, 16'h2222);
    check_eq("nto_ir", ir, 16'h2222);
`endif

    // reset mid-fetch, then a late valid
    cycle(1, 0, 0, 0, 0, '0);
    idle(2);
    check_eq("mid_busy", fetch_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 1, 16'hFFFF);
    check_eq("late_ir", ir, 16'h0000);
    check_eq("late_irv", ir_valid, 0);
    check_eq("late_busy", fetch_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
